// File: rtl/aquaflex5a_seq_ctrl_if.sv
// Command and actuation bundle for the aquaflex5a sequencer.
// The abort line exists only when AQUAFLEX5A_ABORT_EN is defined.
interface aquaflex5a_seq_ctrl_if #(
  parameter int STROKE_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_src;
  logic [2:0]          cmd_dst;
  logic [STROKE_W-1:0] cmd_strokes;
  logic [4:0]          in_valve;
  logic [4:0]          out_valve;
  logic [2:0]          pumpa_v;
  logic [2:0]          pumpc_v;
  logic [2:0]          mix_v;
  logic                busy;
  logic                done;
  logic                err;
`ifdef AQUAFLEX5A_ABORT_EN
  logic                abort;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_strokes, abort,
    input  cmd_ready, in_valve, out_valve, pumpa_v, pumpc_v, mix_v, busy, done, err
  );
  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_strokes, abort,
    output cmd_ready, in_valve, out_valve, pumpa_v, pumpc_v, mix_v, busy, done, err
  );
`else
  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_strokes,
    input  cmd_ready, in_valve, out_valve, pumpa_v, pumpc_v, mix_v, busy, done, err
  );
  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_strokes,
    output cmd_ready, in_valve, out_valve, pumpa_v, pumpc_v, mix_v, busy, done, err
  );
`endif
endinterface

// File: rtl/aquaflex5a_seq_ctrl.sv
// Load/mix/unload valve and pump sequencer for the aquaflex5a flow netlist.
// Optional abort input enabled by defining AQUAFLEX5A_ABORT_EN.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// LOAD     | source inlet open, PumpA cycling
// SETTLE1  | everything closed for one step time
// MIX      | Mixer1 cycling
// SETTLE2  | everything closed for one step time
// UNLOAD   | destination outlet open, PumpC cycling
// DONE     | one-cycle completion pulse
// ABORTED  | one-cycle err pulse after abort
module aquaflex5a_seq_ctrl #(
  parameter int PHASE_CYCLES = 4,
  parameter int STROKE_W     = 8,
  parameter int MIX_STROKES  = 16
) (
  input logic                  clk,
  input logic                  rst,
  aquaflex5a_seq_ctrl_if.slave bus
);
  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES + 1) : 1;
  localparam int MW = $clog2(MIX_STROKES + 1);
  localparam logic [PW-1:0] PH_RELOAD = PW'(PHASE_CYCLES - 1);
  localparam logic [MW-1:0] MIX_LAST  = MW'(MIX_STROKES - 1);
  localparam logic [2:0]    CLOSED    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE1, S_MIX, S_SETTLE2, S_UNLOAD, S_DONE, S_ABORTED
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_phase, w_phase_nxt;
  logic [2:0]          r_step, w_step_nxt;
  logic [STROKE_W-1:0] r_stroke, w_stroke_nxt;
  logic [STROKE_W-1:0] r_strokes, w_strokes_nxt;
  logic [MW-1:0]       r_mix, w_mix_nxt;
  logic [2:0]          r_src, w_src_nxt, r_dst, w_dst_nxt;

  logic       r_cmd_ready, r_busy, r_done, r_err;
  logic [4:0] r_in_valve, r_out_valve;
  logic [2:0] r_pumpa_v, r_pumpc_v, r_mix_v;
  logic       w_cmd_ready_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [4:0] w_in_valve_nxt, w_out_valve_nxt;
  logic [2:0] w_pumpa_v_nxt, w_pumpc_v_nxt, w_mix_v_nxt;

  logic w_accept, w_cmd_ok, w_abort, w_active, w_phase_tc, w_stroke_end;

  function automatic logic [2:0] f_pattern(input logic [2:0] step);
    case (step)
      3'd0:    f_pattern = 3'b011;
      3'd1:    f_pattern = 3'b001;
      3'd2:    f_pattern = 3'b101;
      3'd3:    f_pattern = 3'b100;
      3'd4:    f_pattern = 3'b110;
      3'd5:    f_pattern = 3'b010;
      default: f_pattern = CLOSED;
    endcase
  endfunction

`ifdef AQUAFLEX5A_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept     = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_cmd_ok     = (bus.cmd_src <= 3'd4) && (bus.cmd_dst <= 3'd4) &&
                        (bus.cmd_strokes != '0);
  assign w_active     = (r_state == S_LOAD) || (r_state == S_SETTLE1) ||
                        (r_state == S_MIX) || (r_state == S_SETTLE2) ||
                        (r_state == S_UNLOAD);
  assign w_phase_tc   = (r_phase == '0);
  assign w_stroke_end = w_phase_tc && (r_step == 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_step      <= '0;
      r_stroke    <= '0;
      r_strokes   <= '0;
      r_mix       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_in_valve  <= '0;
      r_out_valve <= '0;
      r_pumpa_v   <= CLOSED;
      r_pumpc_v   <= CLOSED;
      r_mix_v     <= CLOSED;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_step      <= w_step_nxt;
      r_stroke    <= w_stroke_nxt;
      r_strokes   <= w_strokes_nxt;
      r_mix       <= w_mix_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_in_valve  <= w_in_valve_nxt;
      r_out_valve <= w_out_valve_nxt;
      r_pumpa_v   <= w_pumpa_v_nxt;
      r_pumpc_v   <= w_pumpc_v_nxt;
      r_mix_v     <= w_mix_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_strokes_nxt = r_strokes;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_cmd_ok) begin
          w_state_nxt   = S_LOAD;
          w_strokes_nxt = bus.cmd_strokes;
          w_src_nxt     = bus.cmd_src;
          w_dst_nxt     = bus.cmd_dst;
        end
      end
      S_LOAD:
        if (w_stroke_end && (r_stroke == r_strokes - 1'b1)) w_state_nxt = S_SETTLE1;
      S_SETTLE1:
        if (w_phase_tc) w_state_nxt = S_MIX;
      S_MIX:
        if (w_stroke_end && (r_mix == MIX_LAST)) w_state_nxt = S_SETTLE2;
      S_SETTLE2:
        if (w_phase_tc) w_state_nxt = S_UNLOAD;
      S_UNLOAD:
        if (w_stroke_end && (r_stroke == r_strokes - 1'b1)) w_state_nxt = S_DONE;
      default:
        w_state_nxt = S_IDLE;
    endcase
    if (w_active && w_abort) w_state_nxt = S_ABORTED;

    // every state change restarts the step timer so each stage begins at step 0
    w_phase_nxt  = r_phase;
    w_step_nxt   = r_step;
    w_stroke_nxt = r_stroke;
    w_mix_nxt    = r_mix;
    if (w_state_nxt != r_state) begin
      w_phase_nxt  = PH_RELOAD;
      w_step_nxt   = '0;
      w_stroke_nxt = '0;
      w_mix_nxt    = '0;
    end else if (w_active) begin
      if (w_phase_tc) begin
        w_phase_nxt = PH_RELOAD;
        w_step_nxt  = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
        if (r_step == 3'd5) begin
          if (r_state == S_MIX) w_mix_nxt = r_mix + 1'b1;
          else                  w_stroke_nxt = r_stroke + 1'b1;
        end
      end else begin
        w_phase_nxt = r_phase - 1'b1;
      end
    end
  end

  // outputs decoded from the next state so they change together with r_state
  always_comb begin
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SETTLE1) ||
                      (w_state_nxt == S_MIX) || (w_state_nxt == S_SETTLE2) ||
                      (w_state_nxt == S_UNLOAD);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_err_nxt       = (w_state_nxt == S_ABORTED) || (w_accept && !w_cmd_ok);
    w_in_valve_nxt  = '0;
    w_out_valve_nxt = '0;
    w_pumpa_v_nxt   = CLOSED;
    w_pumpc_v_nxt   = CLOSED;
    w_mix_v_nxt     = CLOSED;
    case (w_state_nxt)
      S_LOAD: begin
        w_in_valve_nxt = 5'b00001 << w_src_nxt;
        w_pumpa_v_nxt  = f_pattern(w_step_nxt);
      end
      S_MIX:
        w_mix_v_nxt = f_pattern(w_step_nxt);
      S_UNLOAD: begin
        w_out_valve_nxt = 5'b00001 << w_dst_nxt;
        w_pumpc_v_nxt   = f_pattern(w_step_nxt);
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.in_valve  = r_in_valve;
  assign bus.out_valve = r_out_valve;
  assign bus.pumpa_v   = r_pumpa_v;
  assign bus.pumpc_v   = r_pumpc_v;
  assign bus.mix_v     = r_mix_v;
endmodule

// File: tb/tb_aquaflex5a_seq_ctrl.sv
// Randomized bench for aquaflex5a_seq_ctrl; expected outputs come from a
// cycle-offset model of the stage durations and the peristaltic step table.
module tb_aquaflex5a_seq_ctrl;
  localparam int P    = 4;
  localparam int SW   = 8;
  localparam int MIXS = 1;
  localparam logic [2:0] CL = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aquaflex5a_seq_ctrl_if #(.STROKE_W(SW)) bus ();

  aquaflex5a_seq_ctrl #(
    .PHASE_CYCLES(P),
    .STROKE_W(SW),
    .MIX_STROKES(MIXS)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] pat [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  logic [23:0] w_obs;
  assign w_obs = {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.in_valve,
                  bus.out_valve, bus.pumpa_v, bus.pumpc_v, bus.mix_v};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [23:0] pack(input bit rdy, input bit bsy, input bit dn,
                                       input bit er, input logic [4:0] iv,
                                       input logic [4:0] ov, input logic [2:0] pa,
                                       input logic [2:0] pc, input logic [2:0] mx);
    return {rdy, bsy, dn, er, iv, ov, pa, pc, mx};
  endfunction

  function automatic logic [23:0] idle_v();
    return pack(1, 0, 0, 0, 5'd0, 5'd0, CL, CL, CL);
  endfunction

  function automatic int total_cycles(input int strokes);
    return 2 * strokes * 6 * P + 2 * P + MIXS * 6 * P;
  endfunction

  // expected outputs k cycles after the accepting edge
  function automatic logic [23:0] exp_at(input int src, input int dst,
                                         input int strokes, input int k);
    int L = strokes * 6 * P;
    int M = MIXS * 6 * P;
    int tot = 2 * L + 2 * P + M;
    logic [4:0] oh_s = 5'(1 << src);
    logic [4:0] oh_d = 5'(1 << dst);
    if (k <= L)                return pack(0, 1, 0, 0, oh_s, 5'd0, pat[((k - 1) / P) % 6], CL, CL);
    if (k <= L + P)            return pack(0, 1, 0, 0, 5'd0, 5'd0, CL, CL, CL);
    if (k <= L + P + M)        return pack(0, 1, 0, 0, 5'd0, 5'd0, CL, CL, pat[((k - L - P - 1) / P) % 6]);
    if (k <= L + 2 * P + M)    return pack(0, 1, 0, 0, 5'd0, 5'd0, CL, CL, CL);
    if (k <= tot)              return pack(0, 1, 0, 0, 5'd0, oh_d, CL, pat[((k - L - 2 * P - M - 1) / P) % 6], CL);
    if (k == tot + 1)          return pack(0, 0, 1, 0, 5'd0, 5'd0, CL, CL, CL);
    return idle_v();
  endfunction

  task automatic drive(input int src, input int dst, input int strokes, input bit v);
    bus.cmd_valid   = v;
    bus.cmd_src     = 3'(src);
    bus.cmd_dst     = 3'(dst);
    bus.cmd_strokes = SW'(strokes);
  endtask

  task automatic track(input string tag, input int src, input int dst,
                       input int strokes, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk(tag, w_obs, exp_at(src, dst, strokes, k));
    end
  endtask

  task automatic run_cmd(input string tag, input int src, input int dst, input int strokes);
    @(posedge clk); #1;
    drive(src, dst, strokes, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    track(tag, src, dst, strokes, total_cycles(strokes) + 2);
  endtask

  task automatic run_bad(input string tag, input int src, input int dst, input int strokes);
    @(posedge clk); #1;
    drive(src, dst, strokes, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, w_obs, pack(1, 0, 0, 1, 5'd0, 5'd0, CL, CL, CL));
    @(negedge clk);
    chk({tag, "_idle"}, w_obs, idle_v());
  endtask

  initial begin
    int s, d, n, a, b, c;
    drive(0, 0, 0, 1'b0);
`ifdef AQUAFLEX5A_ABORT_EN
    bus.abort = 1'b0;
`endif
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset", w_obs, idle_v());
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255), 1'b0);
      @(negedge clk);
      chk("idle_hold", w_obs, idle_v());
    end

    run_cmd("nominal", 2, 4, 2);

    run_bad("bad_src", 5, 1, 1);
    run_bad("bad_dst", 1, 7, 1);
    run_bad("bad_strokes", 0, 0, 0);

    // second command held on the bus while the first is running
    a = total_cycles(1);
    b = total_cycles(2);
    @(posedge clk); #1;
    drive(1, 3, 1, 1'b1);
    @(posedge clk); #1;
    drive(4, 0, 2, 1'b1);
    track("b2b_first", 1, 3, 1, a + 2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    track("b2b_second", 4, 0, 2, b + 2);

    // synchronous reset in the middle of LOAD
    @(posedge clk); #1;
    drive(3, 2, 2, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    track("pre_reset", 3, 2, 2, 29);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset", w_obs, idle_v());
    run_cmd("after_reset", 0, 1, 1);

`ifdef AQUAFLEX5A_ABORT_EN
    c = 2 * 6 * P + P + 5;
    @(posedge clk); #1;
    drive(2, 2, 2, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    track("pre_abort", 2, 2, 2, c);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_mix", w_obs, exp_at(2, 2, 2, c + 1));
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("aborted", w_obs, pack(0, 0, 0, 1, 5'd0, 5'd0, CL, CL, CL));
    @(negedge clk);
    chk("abort_idle", w_obs, idle_v());
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_in_idle", w_obs, idle_v());
    @(posedge clk); #1;
    bus.abort = 1'b0;
`else
    c = 0;
`endif

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       run_bad("rnd_bad", $urandom_range(5, 7), $urandom_range(0, 4), $urandom_range(1, 255));
          1:       run_bad("rnd_bad", $urandom_range(0, 4), $urandom_range(5, 7), $urandom_range(1, 255));
          default: run_bad("rnd_bad", $urandom_range(0, 7), $urandom_range(0, 7), 0);
        endcase
      end else begin
        s = $urandom_range(0, 4);
        d = $urandom_range(0, 4);
        n = $urandom_range(1, 3);
        run_cmd("rnd_cmd", s, d, n);
      end
    end

    run_cmd("max_strokes", 4, 0, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
